// File: rtl/vdma_frame_scheduler.sv
// Frame-buffer scheduler for the VDMA read core: re-arms the core once per frame with the
// newest fully written buffer and steers the frame writer away from the buffer being read.
module vdma_frame_scheduler #(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int INDEX_WIDTH     = 8,
   parameter int BUF_NUM         = 3,
   parameter int STAT_WIDTH      = 16
) (
   input  logic                       aresetn,
   input  logic                       aclk,
   input  logic                       cfg_enable,
   input  logic [AXI4_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [AXI4_ADDR_WIDTH-1:0] cfg_buf_size,
   input  logic                       wr_frame_done,
   output logic [1:0]                 wr_buf_index,
   output logic                       core_enable,
   output logic                       core_update,
   output logic [AXI4_ADDR_WIDTH-1:0] core_addr,
   input  logic                       core_busy,
   input  logic [INDEX_WIDTH-1:0]     core_index,
   output logic [1:0]                 rd_buf_index,
   output logic                       sched_busy,
   output logic [STAT_WIDTH-1:0]      stat_repeat,
   output logic [STAT_WIDTH-1:0]      stat_drop
);
   typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

   state_t                     state, state_n;
   logic [1:0]                 newest;
   logic                       newest_valid, newest_read;
   logic [INDEX_WIDTH-1:0]     idx_prev;
   logic                       issue, acked, repeat_hit, drop_hit;
   logic [1:0]                 sel_buf, rd_next, wr_next;
   logic [AXI4_ADDR_WIDTH-1:0] addr_next;

   function automatic logic [1:0] buf_inc(input logic [1:0] b);
      return (b == 2'(BUF_NUM - 1)) ? 2'd0 : b + 2'd1;
   endfunction

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (cfg_enable && !core_busy) state_n = ISSUE;
         ISSUE:   if (core_index != idx_prev) state_n = RUN;
         RUN:     if (!core_busy) state_n = cfg_enable ? ISSUE : IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A write finishing in the issue cycle is bypassed straight to the reader.
   always_comb begin
      issue      = (state != ISSUE) && (state_n == ISSUE);
      acked      = (state == ISSUE) && (state_n == RUN);
      sel_buf    = wr_frame_done ? wr_buf_index : (newest_valid ? newest : 2'd0);
      rd_next    = issue ? sel_buf : rd_buf_index;
      wr_next    = buf_inc(wr_buf_index);
      if (wr_next == rd_next) wr_next = buf_inc(wr_next);
      addr_next  = cfg_base_addr + AXI4_ADDR_WIDTH'(sel_buf) * cfg_buf_size;
      repeat_hit = issue && !wr_frame_done && (newest_read || !newest_valid);
      drop_hit   = wr_frame_done && newest_valid && !newest_read;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         core_enable  <= 1'b0;
         core_update  <= 1'b0;
         core_addr    <= '0;
         wr_buf_index <= 2'd0;
         rd_buf_index <= 2'd0;
         sched_busy   <= 1'b0;
         stat_repeat  <= '0;
         stat_drop    <= '0;
         newest       <= 2'd0;
         newest_valid <= 1'b0;
         newest_read  <= 1'b0;
         idx_prev     <= '0;
      end else begin
         sched_busy <= (state_n != IDLE);
         if (issue) begin
            rd_buf_index <= sel_buf;
            core_addr    <= addr_next;
            idx_prev     <= core_index;
            core_enable  <= 1'b1;
            core_update  <= 1'b1;
            newest_read  <= 1'b1;
         end else if (acked) begin
            core_enable  <= 1'b0;
            core_update  <= 1'b0;
         end
         if (repeat_hit) stat_repeat <= stat_repeat + STAT_WIDTH'(1);
         if (drop_hit)   stat_drop   <= stat_drop + STAT_WIDTH'(1);
         if (wr_frame_done) begin
            newest       <= wr_buf_index;
            newest_valid <= 1'b1;
            wr_buf_index <= wr_next;
            if (!issue) newest_read <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vdma_frame_scheduler.sv
// Scoreboard bench for vdma_frame_scheduler: a behavioural buffer-ring model predicts each
// issued frame and each writer index; a monitor compares when the DUT presents them.
module tb_vdma_frame_scheduler;
   localparam int AW = 32;
   localparam int IW = 8;
   localparam int NB = 3;
   localparam int SW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          cfg_enable = 1'b0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [AW-1:0] cfg_buf_size = '0;
   logic          wr_frame_done = 1'b0;
   logic [1:0]    wr_buf_index, rd_buf_index;
   logic          core_enable, core_update, core_busy, sched_busy;
   logic [AW-1:0] core_addr;
   logic [IW-1:0] core_index;
   logic [SW-1:0] stat_repeat, stat_drop;

   int checks = 0;
   int errors = 0;
   int frame_len = 6;   // 0 selects a random frame length per frame

   typedef struct packed {
      logic [1:0]    rd;
      logic [AW-1:0] addr;
      logic [SW-1:0] rep;
      logic [SW-1:0] drop;
   } exp_t;
   exp_t       exp_q[$];
   logic [1:0] wr_q[$];

   always #5 aclk = ~aclk;

   vdma_frame_scheduler #(.AXI4_ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .BUF_NUM(NB), .STAT_WIDTH(SW)) dut (
      .aresetn(aresetn), .aclk(aclk), .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
      .cfg_buf_size(cfg_buf_size), .wr_frame_done(wr_frame_done), .wr_buf_index(wr_buf_index),
      .core_enable(core_enable), .core_update(core_update), .core_addr(core_addr),
      .core_busy(core_busy), .core_index(core_index), .rd_buf_index(rd_buf_index),
      .sched_busy(sched_busy), .stat_repeat(stat_repeat), .stat_drop(stat_drop));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Read core: accepts ctl_enable while idle, bumps its index, stays busy for a frame.
   int core_cnt;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         core_busy  <= 1'b0;
         core_index <= '0;
         core_cnt   <= 0;
      end else if (!core_busy) begin
         if (core_enable) begin
            core_busy  <= 1'b1;
            core_index <= core_index + IW'(1);
            core_cnt   <= (frame_len == 0) ? int'($urandom_range(2, 10)) : frame_len;
         end
      end else if (core_cnt <= 1) core_busy <= 1'b0;
      else core_cnt <= core_cnt - 1;
   end

   // Reference model: ring of buffers tracked as newest / valid / already-read.
   logic [1:0]    m_newest = 2'd0, m_rd = 2'd0, m_wr = 2'd0;
   logic          m_valid = 1'b0, m_read = 1'b0, m_en = 1'b0;
   logic [SW-1:0] m_rep = '0, m_drop = '0;

   always begin
      logic          d, en0;
      logic [AW-1:0] base, size;
      int            k;
      exp_t          e;
      @(posedge aclk);
      d = wr_frame_done; en0 = m_en; base = cfg_base_addr; size = cfg_buf_size;
      #1;
      if (!aresetn) begin
         m_newest = 2'd0; m_rd = 2'd0; m_wr = 2'd0; m_valid = 1'b0; m_read = 1'b0;
         m_en = 1'b0; m_rep = '0; m_drop = '0;
         exp_q.delete(); wr_q.delete();
      end else begin
         m_en = core_enable;
         if (d) begin
            if (m_valid && !m_read) m_drop = m_drop + 1'b1;
            m_newest = m_wr; m_valid = 1'b1; m_read = 1'b0;
         end
         if (core_enable && !en0) begin
            if (!m_valid || m_read) m_rep = m_rep + 1'b1;
            m_rd = m_valid ? m_newest : 2'd0;
            m_read = 1'b1;
            e.rd = m_rd; e.addr = base + size * 32'(m_rd); e.rep = m_rep; e.drop = m_drop;
            exp_q.push_back(e);
         end
         if (d) begin
            k = int'(m_wr);
            do k = (k + 1) % NB; while (k == int'(m_newest) || k == int'(m_rd));
            m_wr = 2'(k);
            wr_q.push_back(m_wr);
         end
      end
   end

   // Monitor: one comparison set per issued frame, writer index after each completion.
   logic mon_prev = 1'b0;
   int   hi_cnt = 0;
   always @(negedge aclk) begin
      exp_t e;
      if (!aresetn) begin
         mon_prev = 1'b0; hi_cnt = 0;
      end else begin
         if (core_enable && !mon_prev) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL issue_unexpected: core_enable rose, expected no issue");
            end else begin
               e = exp_q.pop_front();
               chk("rd_buf_index", 64'(rd_buf_index), 64'(e.rd));
               chk("core_addr", 64'(core_addr), 64'(e.addr));
               chk("stat_repeat", 64'(stat_repeat), 64'(e.rep));
               chk("stat_drop", 64'(stat_drop), 64'(e.drop));
               chk("core_update", 64'(core_update), 64'(1));
            end
         end
         if (core_enable) hi_cnt++;
         else if (mon_prev) begin
            chk("enable_width", 64'(hi_cnt), 64'(2));
            hi_cnt = 0;
         end
         mon_prev = core_enable;
         if (wr_q.size() != 0) chk("wr_buf_index", 64'(wr_buf_index), 64'(wr_q.pop_front()));
         if (m_valid) chk("wr_ne_rd", 64'(wr_buf_index != rd_buf_index), 64'(1));
      end
   end

   function automatic logic cond(input int which);
      case (which)
         0:       return sched_busy && !core_enable && core_busy;   // frame running
         1:       return core_enable;
         2:       return !sched_busy;
         default: return !core_busy;
      endcase
   endfunction

   task automatic wait_for(input int which, input string name);
      int n = 0;
      while (!cond(which)) begin
         if (n == 500) begin
            checks++; errors++;
            $display("FAIL timeout_%s: not reached in 500 cycles, expected reached", name);
            return;
         end
         @(negedge aclk);
         n++;
      end
   endtask

   task automatic pulse_done();
      wr_frame_done = 1'b1;
      @(negedge aclk);
      wr_frame_done = 1'b0;
   endtask

   initial begin
      int         n;
      logic [1:0] idx;
      logic [SW-1:0] rep0;
      repeat (3) @(negedge aclk);
      chk("rst_core_enable", 64'(core_enable), 64'(0));
      chk("rst_core_update", 64'(core_update), 64'(0));
      chk("rst_core_addr", 64'(core_addr), 64'(0));
      chk("rst_wr_buf_index", 64'(wr_buf_index), 64'(0));
      chk("rst_rd_buf_index", 64'(rd_buf_index), 64'(0));
      chk("rst_sched_busy", 64'(sched_busy), 64'(0));
      chk("rst_stat_repeat", 64'(stat_repeat), 64'(0));
      chk("rst_stat_drop", 64'(stat_drop), 64'(0));
      #2 aresetn = 1'b1;

      @(negedge aclk);
      cfg_base_addr = 32'h1000_0000; cfg_buf_size = 32'h0020_0000; cfg_enable = 1'b1;
      @(negedge aclk);
      chk("enable_latency_idle", 64'(core_enable), 64'(1));
      chk("sched_busy_issue", 64'(sched_busy), 64'(1));

      wait_for(0, "run1"); pulse_done(); wait_for(1, "issue_after_write0");
      wait_for(0, "run2"); pulse_done(); wait_for(1, "issue_after_write1");

      frame_len = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge aclk);
         cfg_enable    = ($urandom_range(0, 9) != 0);
         wr_frame_done = ($urandom_range(0, 4) == 0);
      end
      @(negedge aclk);
      wr_frame_done = 1'b0; cfg_enable = 1'b1; frame_len = 6;

      // completion in the same cycle the next frame is scheduled
      wait_for(0, "run_bypass"); wait_for(3, "busy_fall");
      idx = m_wr; rep0 = m_rep;
      pulse_done();
      chk("bypass_enable", 64'(core_enable), 64'(1));
      chk("bypass_rd", 64'(rd_buf_index), 64'(idx));
      chk("bypass_repeat", 64'(stat_repeat), 64'(rep0));
      chk("bypass_wr_differs", 64'(wr_buf_index != idx), 64'(1));

      wait_for(0, "run_drop_enable");
      cfg_enable = 1'b0;
      wait_for(2, "idle_after_drop");
      n = 0;
      repeat (20) begin
         @(negedge aclk);
         if (core_enable) n++;
      end
      chk("no_issue_when_disabled", 64'(n), 64'(0));
      chk("idle_sched_busy", 64'(sched_busy), 64'(0));
      cfg_enable = 1'b1; frame_len = 40;
      @(negedge aclk);
      chk("enable_latency_reenable", 64'(core_enable), 64'(1));

      #2 aresetn = 1'b0;
      #1;
      chk("async_rst_ctrl", 64'({core_enable, core_update, wr_buf_index, rd_buf_index, sched_busy}), 64'(0));
      chk("async_rst_addr", 64'(core_addr), 64'(0));
      chk("async_rst_stats", 64'({stat_repeat, stat_drop}), 64'(0));
      @(negedge aclk);
      #2 aresetn = 1'b1;
      @(negedge aclk);
      chk("restart_after_reset", 64'(core_enable), 64'(1));

      wait_for(0, "run_three_writes");
      pulse_done(); @(negedge aclk);
      pulse_done(); @(negedge aclk);
      pulse_done();
      chk("three_writes_drop", 64'(stat_drop), 64'(2));
      frame_len = 6;
      wait_for(1, "issue_after_three_writes");

      @(negedge aclk);
      cfg_enable = 1'b0;
      wait_for(2, "final_idle");
      repeat (3) @(negedge aclk);
      chk("frames_drained", 64'(exp_q.size()), 64'(0));
      chk("writes_drained", 64'(wr_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
